// File: rtl/ahbl_arbiter_if.sv
// AHB-Lite arbiter bus bundle: N upstream master ports plus one downstream port.
// Ports: src_* carry the per-master address/data phases (packed, port 0 in LSBs),
//        dst_* carry the muxed downstream transfer; slave = arbiter view, master = environment view.
interface ahbl_arbiter_if #(
    parameter int N_PORTS = 2,
    parameter int W_ADDR  = 32,
    parameter int W_DATA  = 32
);
    logic [N_PORTS-1:0]        src_hready;
    logic [N_PORTS-1:0]        src_hresp;
    logic [N_PORTS*W_ADDR-1:0] src_haddr;
    logic [N_PORTS-1:0]        src_hwrite;
    logic [N_PORTS*2-1:0]      src_htrans;
    logic [N_PORTS*3-1:0]      src_hsize;
    logic [N_PORTS*3-1:0]      src_hburst;
    logic [N_PORTS*4-1:0]      src_hprot;
    logic [N_PORTS-1:0]        src_hmastlock;
    logic [N_PORTS*W_DATA-1:0] src_hwdata;
    logic [N_PORTS*W_DATA-1:0] src_hrdata;

    logic                      dst_hready;
    logic                      dst_hready_resp;
    logic                      dst_hresp;
    logic [W_ADDR-1:0]         dst_haddr;
    logic                      dst_hwrite;
    logic [1:0]                dst_htrans;
    logic [2:0]                dst_hsize;
    logic [2:0]                dst_hburst;
    logic [3:0]                dst_hprot;
    logic                      dst_hmastlock;
    logic [W_DATA-1:0]         dst_hwdata;
    logic [W_DATA-1:0]         dst_hrdata;

    // Arbiter side: slave to the upstream masters, master to the downstream slave.
    modport slave (
        output src_hready, src_hresp, src_hrdata,
        input  src_haddr, src_hwrite, src_htrans, src_hsize, src_hburst,
        input  src_hprot, src_hmastlock, src_hwdata,
        output dst_hready, dst_haddr, dst_hwrite, dst_htrans, dst_hsize,
        output dst_hburst, dst_hprot, dst_hmastlock, dst_hwdata,
        input  dst_hready_resp, dst_hresp, dst_hrdata
    );

    // Environment side: upstream masters plus the downstream slave.
    modport master (
        input  src_hready, src_hresp, src_hrdata,
        output src_haddr, src_hwrite, src_htrans, src_hsize, src_hburst,
        output src_hprot, src_hmastlock, src_hwdata,
        input  dst_hready, dst_haddr, dst_hwrite, dst_htrans, dst_hsize,
        input  dst_hburst, dst_hprot, dst_hmastlock, dst_hwdata,
        output dst_hready_resp, dst_hresp, dst_hrdata
    );
endinterface

// File: rtl/ahbl_arbiter.sv
// Purpose: N-master to 1-slave AHB-Lite arbiter, round-robin, losers' address phases held and replayed.
// Latency: uncontended live request passes through combinationally (0 cycles); buffered ones issue on win.
// Backpressure: a buffered master sees src_hready=0 until its replayed transfer's data phase completes.
// Ports: clk, rst (sync, active-high), bus (ahbl_arbiter_if.slave: src_* upstream, dst_* downstream).
// Option: define AHBL_ARBITER_LOCK_EN to make hmastlock hold the grant; otherwise it is only forwarded.
module ahbl_arbiter #(
    parameter int N_PORTS = 2,
    parameter int W_ADDR  = 32,
    parameter int W_DATA  = 32
) (
    input  logic          clk,
    input  logic          rst,
    ahbl_arbiter_if.slave bus
);
    localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    typedef struct packed {
        logic [W_ADDR-1:0] addr;
        logic              write;
        logic [2:0]        size;
        logic [2:0]        burst;
        logic [3:0]        prot;
        logic              mastlock;
    } req_t;

    req_t               buf_q    [N_PORTS];
    req_t               buf_d    [N_PORTS];
    req_t               live_req [N_PORTS];
    req_t               cand_req [N_PORTS];
    req_t               gnt_req;
    logic [N_PORTS-1:0] buf_vld_q, buf_vld_d;
    logic [N_PORTS-1:0] live, cand, src_hready_o, src_hresp_o;
    logic [N_PORTS-1:0] unused_htrans_lsb;
    logic [PW-1:0]      rr_q, rr_d, dph_owner_q, dph_owner_d, hold_port_q, hold_port_d, gnt_port;
    logic               dph_valid_q, dph_valid_d, hold_vld_q, hold_vld_d, gnt_vld, accept;
`ifdef AHBL_ARBITER_LOCK_EN
    logic               lock_vld_q, lock_vld_d;
    logic [PW-1:0]      lock_port_q, lock_port_d;
`endif

    // Upstream response: buffered ports stall, the data-phase owner sees the slave, others idle-ready.
    always_comb begin
        for (int i = 0; i < N_PORTS; i++) begin
            src_hready_o[i] = 1'b1;
            src_hresp_o[i]  = 1'b0;
            if (dph_valid_q && dph_owner_q == PW'(i)) begin
                src_hready_o[i] = bus.dst_hready_resp;
                src_hresp_o[i]  = bus.dst_hresp;
            end
            if (buf_vld_q[i]) begin
                src_hready_o[i] = 1'b0;
            end
        end
    end

    assign bus.src_hready = src_hready_o;
    assign bus.src_hresp  = src_hresp_o;
    assign bus.src_hrdata = {N_PORTS{bus.dst_hrdata}};
    assign bus.dst_hready = bus.dst_hready_resp;

    // Per-port candidate: the held request has precedence over whatever is on the live bus.
    always_comb begin
        for (int i = 0; i < N_PORTS; i++) begin
            live_req[i].addr     = bus.src_haddr[i*W_ADDR +: W_ADDR];
            live_req[i].write    = bus.src_hwrite[i];
            live_req[i].size     = bus.src_hsize[i*3 +: 3];
            live_req[i].burst    = bus.src_hburst[i*3 +: 3];
            live_req[i].prot     = bus.src_hprot[i*4 +: 4];
            live_req[i].mastlock = bus.src_hmastlock[i];
            live[i]              = bus.src_htrans[2*i+1] & src_hready_o[i];
            cand[i]              = buf_vld_q[i] | live[i];
            cand_req[i]          = buf_vld_q[i] ? buf_q[i] : live_req[i];
            // SEQ/NSEQ distinction is dropped: every issued beat goes out as NSEQ.
            unused_htrans_lsb[i] = bus.src_htrans[2*i];
        end
    end

    // Grant. A request offered while the slave stalled keeps the grant so the
    // downstream address phase stays stable until it is accepted.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_port = '0;
        if (hold_vld_q) begin
            gnt_vld  = cand[hold_port_q];
            gnt_port = hold_port_q;
        end else begin
            // Descending scan so the nearest port after rr_q is the last (winning) assignment.
            for (int k = N_PORTS - 1; k >= 0; k--) begin
                if (cand[(int'(rr_q) + k) % N_PORTS]) begin
                    gnt_vld  = 1'b1;
                    gnt_port = PW'((int'(rr_q) + k) % N_PORTS);
                end
            end
        end
`ifdef AHBL_ARBITER_LOCK_EN
        if (lock_vld_q) begin
            gnt_vld  = cand[lock_port_q];
            gnt_port = lock_port_q;
        end
`endif
    end

    assign gnt_req = cand_req[gnt_port];
    assign accept  = gnt_vld & bus.dst_hready_resp;

    always_comb begin
        bus.dst_htrans    = gnt_vld ? 2'b10 : 2'b00;
        bus.dst_haddr     = gnt_vld ? gnt_req.addr : '0;
        bus.dst_hwrite    = gnt_vld & gnt_req.write;
        bus.dst_hsize     = gnt_vld ? gnt_req.size : 3'b000;
        bus.dst_hburst    = gnt_vld ? gnt_req.burst : 3'b000;
        bus.dst_hprot     = gnt_vld ? gnt_req.prot : 4'b0000;
        bus.dst_hmastlock = gnt_vld & gnt_req.mastlock;
    end

    assign bus.dst_hwdata = bus.src_hwdata[int'(dph_owner_q)*W_DATA +: W_DATA];

    always_comb begin
        buf_d       = buf_q;
        buf_vld_d   = buf_vld_q;
        rr_d        = rr_q;
        dph_valid_d = dph_valid_q;
        dph_owner_d = dph_owner_q;
        hold_vld_d  = gnt_vld & ~bus.dst_hready_resp;
        hold_port_d = gnt_port;
        for (int i = 0; i < N_PORTS; i++) begin
            if (buf_vld_q[i]) begin
                if (accept && gnt_port == PW'(i)) buf_vld_d[i] = 1'b0;
            end else if (live[i] && !(accept && gnt_port == PW'(i))) begin
                buf_vld_d[i] = 1'b1;
                buf_d[i]     = live_req[i];
            end
        end
        if (accept) begin
            rr_d        = (gnt_port == PW'(N_PORTS - 1)) ? '0 : gnt_port + PW'(1);
            dph_valid_d = 1'b1;
            dph_owner_d = gnt_port;
        end else if (bus.dst_hready_resp) begin
            dph_valid_d = 1'b0;
        end
    end

`ifdef AHBL_ARBITER_LOCK_EN
    // Lock follows the hmastlock of each accepted phase; an IDLE from the locked port also drops it.
    always_comb begin
        lock_vld_d  = lock_vld_q;
        lock_port_d = lock_port_q;
        if (accept) begin
            lock_vld_d  = gnt_req.mastlock;
            lock_port_d = gnt_port;
        end else if (lock_vld_q && !buf_vld_q[lock_port_q] && src_hready_o[lock_port_q]
                     && !bus.src_htrans[2*int'(lock_port_q)+1]) begin
            lock_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_vld_q  <= 1'b0;
            lock_port_q <= '0;
        end else begin
            lock_vld_q  <= lock_vld_d;
            lock_port_q <= lock_port_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_PORTS; i++) buf_q[i] <= '0;
            buf_vld_q   <= '0;
            rr_q        <= '0;
            dph_valid_q <= 1'b0;
            dph_owner_q <= '0;
            hold_vld_q  <= 1'b0;
            hold_port_q <= '0;
        end else begin
            buf_q       <= buf_d;
            buf_vld_q   <= buf_vld_d;
            rr_q        <= rr_d;
            dph_valid_q <= dph_valid_d;
            dph_owner_q <= dph_owner_d;
            hold_vld_q  <= hold_vld_d;
            hold_port_q <= hold_port_d;
        end
    end
endmodule

// File: tb/tb_ahbl_arbiter.sv
// Testbench for ahbl_arbiter with two masters and a zero-wait memory slave whose
// stall/error responses are driven by the stimulus.
module tb_ahbl_arbiter;
    localparam int N  = 2;
    localparam int WA = 32;
    localparam int WD = 32;
    localparam logic [1:0] NS = 2'b10;
    localparam logic [1:0] ID = 2'b00;
    localparam logic [31:0] D0 = 32'hD0D0_0020;
    localparam logic [31:0] D1 = 32'hD1D1_0044;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ahbl_arbiter_if #(.N_PORTS(N), .W_ADDR(WA), .W_DATA(WD)) bus ();
    ahbl_arbiter #(.N_PORTS(N), .W_ADDR(WA), .W_DATA(WD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Downstream memory slave: single-cycle, words indexed by addr[9:2].
    logic [31:0] mem [256];
    logic        s_vld, s_write;
    logic [31:0] s_addr;
    always @(posedge clk) begin
        if (rst) begin
            s_vld   <= 1'b0;
            s_write <= 1'b0;
            s_addr  <= '0;
            for (int i = 0; i < 256; i++)
                mem[i] <= (i == 4) ? 32'hCAFE_0010 : (i == 5) ? 32'hCAFE_0014 : 32'h0;
        end else if (bus.dst_hready_resp) begin
            if (s_vld && s_write && !bus.dst_hresp) mem[s_addr[9:2]] <= bus.dst_hwdata;
            s_vld   <= bus.dst_htrans[1] & bus.dst_hready;
            s_write <= bus.dst_hwrite;
            s_addr  <= bus.dst_haddr;
        end
    end
    assign bus.dst_hrdata = mem[s_addr[9:2]];

    // Scoreboard: expected downstream address phases in issue order.
    typedef struct packed { logic [31:0] addr; logic write; } exp_t;
    exp_t sb_q [$];
    exp_t sb_e;
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.dst_htrans[1] && bus.dst_hready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: issued addr %h, none expected", bus.dst_haddr);
            end else begin
                sb_e = sb_q.pop_front();
                chk("sb_addr", {32'h0, bus.dst_haddr}, {32'h0, sb_e.addr});
                chk("sb_write", {63'h0, bus.dst_hwrite}, {63'h0, sb_e.write});
            end
        end
    end

    typedef struct {
        logic [1:0]  t0;  logic [31:0] a0; logic w0; logic [31:0] d0;
        logic [1:0]  t1;  logic [31:0] a1; logic w1; logic [31:0] d1;
        logic        p0,  p1;
        logic [1:0]  e_trans; logic [31:0] e_addr; logic [1:0] e_rdy;
        logic        c_wd; logic [31:0] e_wd;
        logic        c_rd; int rd_port; logic [31:0] e_rd;
    } vec_t;
    vec_t tbl [11];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [1:0] t0, input logic [31:0] a0, input logic w0,
                       input logic [1:0] t1, input logic [31:0] a1, input logic w1);
        bus.src_htrans = {t1, t0};
        bus.src_haddr  = {a1, a0};
        bus.src_hwrite = {w1, w0};
    endtask

    task automatic push(input logic [31:0] a, input logic w);
        sb_q.push_back('{addr: a, write: w});
    endtask

    initial begin
        // single reads, two-way write contention, then four-way alternation
        tbl[0]  = '{NS, 32'h10, 1'b0, 32'h0, ID, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, NS, 32'h10, 2'b11, 1'b0, 32'h0, 1'b0, 0, 32'h0};
        tbl[1]  = '{ID, 32'h0, 1'b0, 32'h0, NS, 32'h14, 1'b0, 32'h0, 1'b0, 1'b1, NS, 32'h14, 2'b11, 1'b0, 32'h0, 1'b1, 0, 32'hCAFE_0010};
        tbl[2]  = '{ID, 32'h0, 1'b0, 32'h0, ID, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, ID, 32'h0, 2'b11, 1'b0, 32'h0, 1'b1, 1, 32'hCAFE_0014};
        tbl[3]  = '{NS, 32'h20, 1'b1, 32'h0, NS, 32'h44, 1'b1, 32'h0, 1'b1, 1'b1, NS, 32'h20, 2'b11, 1'b0, 32'h0, 1'b0, 0, 32'h0};
        tbl[4]  = '{ID, 32'h0, 1'b0, D0, ID, 32'h0, 1'b0, D1, 1'b0, 1'b0, NS, 32'h44, 2'b01, 1'b1, D0, 1'b0, 0, 32'h0};
        tbl[5]  = '{ID, 32'h0, 1'b0, 32'h0, ID, 32'h0, 1'b0, D1, 1'b0, 1'b0, ID, 32'h0, 2'b11, 1'b1, D1, 1'b0, 0, 32'h0};
        tbl[6]  = '{NS, 32'h100, 1'b0, 32'h0, NS, 32'h104, 1'b0, 32'h0, 1'b1, 1'b1, NS, 32'h100, 2'b11, 1'b0, 32'h0, 1'b0, 0, 32'h0};
        tbl[7]  = '{NS, 32'h108, 1'b0, 32'h0, NS, 32'h10C, 1'b0, 32'h0, 1'b1, 1'b1, NS, 32'h104, 2'b01, 1'b0, 32'h0, 1'b0, 0, 32'h0};
        tbl[8]  = '{ID, 32'h0, 1'b0, 32'h0, NS, 32'h10C, 1'b0, 32'h0, 1'b0, 1'b0, NS, 32'h108, 2'b10, 1'b0, 32'h0, 1'b0, 0, 32'h0};
        tbl[9]  = '{ID, 32'h0, 1'b0, 32'h0, ID, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, NS, 32'h10C, 2'b01, 1'b0, 32'h0, 1'b0, 0, 32'h0};
        tbl[10] = '{ID, 32'h0, 1'b0, 32'h0, ID, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, ID, 32'h0, 2'b11, 1'b0, 32'h0, 1'b0, 0, 32'h0};

        rst                 = 1'b1;
        bus.dst_hready_resp = 1'b1;
        bus.dst_hresp       = 1'b0;
        bus.src_hsize       = {3'b001, 3'b010};
        bus.src_hburst      = '0;
        bus.src_hprot       = {4'b1010, 4'b0011};
        bus.src_hmastlock   = '0;
        bus.src_hwdata      = '0;
        drv(ID, 32'h0, 1'b0, ID, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        chk("rst_hready", {62'h0, bus.src_hready}, 64'h3);
        chk("rst_hresp", {62'h0, bus.src_hresp}, 64'h0);
        chk("rst_htrans", {62'h0, bus.dst_htrans}, 64'h0);

        for (int r = 0; r < 11; r++) begin
            step();
            drv(tbl[r].t0, tbl[r].a0, tbl[r].w0, tbl[r].t1, tbl[r].a1, tbl[r].w1);
            bus.src_hwdata = {tbl[r].d1, tbl[r].d0};
            if (tbl[r].p0) push(tbl[r].a0, tbl[r].w0);
            if (tbl[r].p1) push(tbl[r].a1, tbl[r].w1);
            #2;
            chk($sformatf("row%0d_htrans", r), {62'h0, bus.dst_htrans}, {62'h0, tbl[r].e_trans});
            chk($sformatf("row%0d_haddr", r), {32'h0, bus.dst_haddr}, {32'h0, tbl[r].e_addr});
            chk($sformatf("row%0d_hready", r), {62'h0, bus.src_hready}, {62'h0, tbl[r].e_rdy});
            if (tbl[r].c_wd)
                chk($sformatf("row%0d_hwdata", r), {32'h0, bus.dst_hwdata}, {32'h0, tbl[r].e_wd});
            if (tbl[r].c_rd)
                chk($sformatf("row%0d_hrdata", r), {32'h0, bus.src_hrdata[tbl[r].rd_port*32 +: 32]}, {32'h0, tbl[r].e_rd});
        end
        chk("mem_0x20", {32'h0, mem[8]}, {32'h0, D0});
        chk("mem_0x44", {32'h0, mem[17]}, {32'h0, D1});

        // Three-cycle downstream stall: buffered port 1 request must stay on the bus.
        step();
        drv(NS, 32'h30, 1'b0, NS, 32'h34, 1'b0);
        push(32'h30, 1'b0);
        push(32'h34, 1'b0);
        #2;
        chk("st0_haddr", {32'h0, bus.dst_haddr}, 64'h30);
        for (int c = 0; c < 3; c++) begin
            step();
            bus.dst_hready_resp = 1'b0;
            drv(ID, 32'h0, 1'b0, ID, 32'h0, 1'b0);
            #2;
            chk($sformatf("st%0d_haddr", c + 1), {32'h0, bus.dst_haddr}, 64'h34);
            chk($sformatf("st%0d_htrans", c + 1), {62'h0, bus.dst_htrans}, {62'h0, NS});
            chk($sformatf("st%0d_hready", c + 1), {62'h0, bus.src_hready}, 64'h0);
            chk($sformatf("st%0d_hprot", c + 1), {60'h0, bus.dst_hprot}, 64'hA);
            chk($sformatf("st%0d_hsize", c + 1), {61'h0, bus.dst_hsize}, 64'h1);
        end
        step();
        bus.dst_hready_resp = 1'b1;
        #2;
        chk("st4_hready", {62'h0, bus.src_hready}, 64'h1);
        step();
        #2;
        chk("st5_htrans", {62'h0, bus.dst_htrans}, 64'h0);
        chk("st5_hready", {62'h0, bus.src_hready}, 64'h3);

        // Two-cycle ERROR on port 1's read; port 1 cancels with IDLE, then re-issues.
        step();
        drv(ID, 32'h0, 1'b0, NS, 32'h3C, 1'b0);
        push(32'h3C, 1'b0);
        #2;
        chk("er0_haddr", {32'h0, bus.dst_haddr}, 64'h3C);
        step();
        bus.dst_hready_resp = 1'b0;
        bus.dst_hresp       = 1'b1;
        drv(ID, 32'h0, 1'b0, NS, 32'h48, 1'b0);
        #2;
        chk("er1_hresp", {62'h0, bus.src_hresp}, 64'h2);
        chk("er1_hready", {62'h0, bus.src_hready}, 64'h1);
        chk("er1_htrans", {62'h0, bus.dst_htrans}, 64'h0);
        step();
        bus.dst_hready_resp = 1'b1;
        drv(ID, 32'h0, 1'b0, ID, 32'h0, 1'b0);
        #2;
        chk("er2_hresp", {62'h0, bus.src_hresp}, 64'h2);
        chk("er2_hready", {62'h0, bus.src_hready}, 64'h3);
        chk("er2_htrans", {62'h0, bus.dst_htrans}, 64'h0);
        step();
        bus.dst_hresp = 1'b0;
        drv(ID, 32'h0, 1'b0, NS, 32'h48, 1'b0);
        push(32'h48, 1'b0);
        #2;
        chk("er3_haddr", {32'h0, bus.dst_haddr}, 64'h48);
        chk("er3_hresp", {62'h0, bus.src_hresp}, 64'h0);
        step();
        drv(ID, 32'h0, 1'b0, ID, 32'h0, 1'b0);

        // Reset while port 0's write sits in its buffer: it must never be replayed.
        step();
        drv(ID, 32'h0, 1'b0, NS, 32'h54, 1'b0);
        push(32'h54, 1'b0);
        #2;
        chk("rs0_haddr", {32'h0, bus.dst_haddr}, 64'h54);
        step();
        bus.dst_hready_resp = 1'b0;
        drv(NS, 32'h50, 1'b1, ID, 32'h0, 1'b0);
        #2;
        chk("rs1_hready", {62'h0, bus.src_hready}, 64'h1);
        chk("rs1_haddr", {32'h0, bus.dst_haddr}, 64'h50);
        step();
        rst = 1'b1;
        drv(ID, 32'h0, 1'b0, ID, 32'h0, 1'b0);
        bus.src_hwdata = {32'h0, 32'h0000_5050};
        #2;
        chk("rs2_hready0", {63'h0, bus.src_hready[0]}, 64'h0);
        step();
        rst = 1'b0;
        bus.dst_hready_resp = 1'b1;
        #2;
        chk("rs3_hready", {62'h0, bus.src_hready}, 64'h3);
        chk("rs3_htrans", {62'h0, bus.dst_htrans}, 64'h0);
        step();
        #2;
        chk("rs4_htrans", {62'h0, bus.dst_htrans}, 64'h0);
        step();
        #2;
        chk("rs_no_replay", {32'h0, mem[20]}, 64'h0);
        chk("sb_empty", 64'(sb_q.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", checks);
        $fatal(1);
    end
endmodule
